// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester-side bus and register-file write port of the shared write arbiter
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW = 8
) ();
  logic hold;
  logic [NREQ-1:0] req;
  logic [3*NREQ-1:0] addr;
  logic [DW*NREQ-1:0] data;
  logic [NREQ-1:0] gnt;
  logic wvalid;
  logic [2:0] waddr;
  logic [7:0] we;
  logic [DW-1:0] wdata;
  modport master (output hold, req, addr, data, input gnt, wvalid, waddr, we, wdata);
  modport slave (input hold, req, addr, data, output gnt, wvalid, waddr, we, wdata);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing one register-file write port among NREQ requesters.
// Optional macro ZERO_REG_EN makes register 0 hard-wired zero (its write enable is suppressed).
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, win, ptr_nxt;
  logic [PW:0] idx;
  logic [NREQ-1:0] elig;
  logic found;
  logic [2:0] wa;
  logic [7:0] we_nxt;
  // the current grantee is masked so nobody wins two cycles in a row
  always_comb begin
    elig = bus.req & ~bus.gnt;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      idx = (idx >= (PW+1)'(NREQ)) ? idx - (PW+1)'(NREQ) : idx;
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win = idx[PW-1:0];
      end
    end
    wa = bus.addr[3*win +: 3];
`ifdef ZERO_REG_EN
    we_nxt = (wa == 3'd0) ? 8'h00 : 8'h01 << wa;
`else
    we_nxt = 8'h01 << wa;
`endif
    ptr_nxt = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      bus.gnt <= '0;
      bus.wvalid <= 1'b0;
      bus.waddr <= '0;
      bus.we <= '0;
      bus.wdata <= '0;
    end else if (!bus.hold && found) begin
      ptr <= ptr_nxt;
      bus.gnt <= NREQ'(1) << win;
      bus.wvalid <= 1'b1;
      bus.waddr <= wa;
      bus.we <= we_nxt;
      bus.wdata <= bus.data[DW*win +: DW];
    end else begin
      bus.gnt <= '0;
      bus.wvalid <= 1'b0;
      bus.we <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed literal checks plus randomized traffic against a behavioural model
module tb_regfile_write_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  regfile_write_arbiter_if #(.NREQ(N), .DW(DW)) bus ();
  regfile_write_arbiter #(.NREQ(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit m_on = 1'b0;
  int m_ptr;
  logic [N-1:0] m_gnt;
  logic m_wv;
  logic [2:0] m_wa;
  logic [7:0] m_we;
  logic [DW-1:0] m_wd;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [7:0] dec(input logic [2:0] a);
    return (ZR && a == 3'd0) ? 8'h00 : 8'h01 << a;
  endfunction
  // reference: winner is the eligible requester nearest to the pointer going upward
  always @(posedge clk) begin
    int best, bd, d;
    if (rst) begin
      m_on = 1'b1;
      m_ptr = 0;
      m_gnt = '0;
      m_wv = 1'b0;
      m_wa = '0;
      m_we = '0;
      m_wd = '0;
    end else begin
      best = -1;
      bd = N;
      for (int i = 0; i < N; i++)
        if (bus.req[i] && !m_gnt[i]) begin
          d = (i - m_ptr + N) % N;
          if (d < bd) begin
            bd = d;
            best = i;
          end
        end
      if (bus.hold || best < 0) begin
        m_gnt = '0;
        m_wv = 1'b0;
        m_we = '0;
      end else begin
        m_gnt = '0;
        m_gnt[best] = 1'b1;
        m_wv = 1'b1;
        m_wa = bus.addr[3*best +: 3];
        m_we = dec(m_wa);
        m_wd = bus.data[DW*best +: DW];
        m_ptr = (best + 1) % N;
      end
    end
  end
  always @(negedge clk)
    if (m_on) begin
      chk("gnt", 32'(bus.gnt), 32'(m_gnt));
      chk("wvalid", 32'(bus.wvalid), 32'(m_wv));
      chk("waddr", 32'(bus.waddr), 32'(m_wa));
      chk("we", 32'(bus.we), 32'(m_we));
      chk("wdata", 32'(bus.wdata), 32'(m_wd));
    end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.req = 4'b1111;
    bus.addr = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    step();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_we", 32'(bus.we), 32'h0);
    chk("rst_wvalid", 32'(bus.wvalid), 32'h0);
    chk("rst_wdata", 32'(bus.wdata), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_gnt", 32'(bus.gnt), 32'(1) << (k % 4));
      chk("rr_we", 32'(bus.we), (ZR && k % 4 == 0) ? 32'h0 : 32'(1) << (k % 4));
      chk("rr_wdata", 32'(bus.wdata), 32'h11 * 32'(k % 4 + 1));
    end
    bus.req = '0;
    step();
    chk("idle_wvalid", 32'(bus.wvalid), 32'h0);
    bus.req = 4'b0100;
    bus.addr[6 +: 3] = 3'd5;
    bus.data[16 +: 8] = 8'hA5;
    step();
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    chk("single_we", 32'(bus.we), 32'h20);
    chk("single_waddr", 32'(bus.waddr), 32'h5);
    chk("single_wdata", 32'(bus.wdata), 32'hA5);
    chk("single_wvalid", 32'(bus.wvalid), 32'h1);
    bus.req = '0;
    step();
    chk("single_idle_wv", 32'(bus.wvalid), 32'h0);
    chk("single_idle_we", 32'(bus.we), 32'h0);
    chk("single_keep_wd", 32'(bus.wdata), 32'hA5);
    bus.req = 4'b0010;
    bus.addr[3 +: 3] = 3'd7;
    bus.data[8 +: 8] = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b2b_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
      chk("b2b_we", 32'(bus.we), (k % 2 == 0) ? 32'h80 : 32'h0);
      chk("b2b_wvalid", 32'(bus.wvalid), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    bus.req = '0;
    step();
    bus.hold = 1'b1;
    bus.req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.hold = 1'b0;
    step();
    chk("unhold_gnt", 32'(bus.gnt), 32'h1);
    step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h2);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_wv", 32'(bus.wvalid), 32'h0);
    chk("mid_rst_waddr", 32'(bus.waddr), 32'h0);
    chk("mid_rst_wdata", 32'(bus.wdata), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step();
    bus.req = 4'b0001;
    bus.addr[0 +: 3] = 3'd0;
    bus.data[0 +: 8] = 8'hFF;
    step();
    chk("zr_gnt", 32'(bus.gnt), 32'h1);
    chk("zr_wvalid", 32'(bus.wvalid), 32'h1);
    chk("zr_we", 32'(bus.we), ZR ? 32'h0 : 32'h1);
    chk("zr_wdata", 32'(bus.wdata), 32'hFF);
    bus.req = '0;
    step();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++)
        if (!bus.req[i] || m_gnt[i]) begin
          bus.req[i] = ($urandom_range(0, 2) != 0);
          bus.addr[3*i +: 3] = 3'($urandom_range(0, 7));
          bus.data[DW*i +: DW] = DW'($urandom);
        end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NREQ independent requesters.
- Round-robin arbitration; at most one write issued per cycle.
- Winner's 3-bit address is decoded to one-hot write enables WE[7:0] for the eight registers, and its data is forwarded on WDATA.
- Sits between the requesting datapath units and the register storage; replaces direct drive of the address decoder.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DW, 8, register data width in bits.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- HOLD  in  1  stalls the write port; no grant issued while high.
- REQ  in  NREQ  per-requester write request; level, held until granted.
- ADDR  in  3*NREQ  requester i's register address in bits [3i+2:3i].
- DATA  in  DW*NREQ  requester i's write data in bits [DW*i+DW-1:DW*i].
- GNT  out  NREQ  one-hot grant; one-cycle pulse.
- WVALID  out  1  a write is presented this cycle.
- WADDR  out  3  registered address of the current write.
- WE  out  8  one-hot decoded write enable; WE[WADDR]=1 when WVALID=1.
- WDATA  out  DW  registered write data.

Behaviour:
- Reset (RST=1 at a rising edge): next cycle GNT=0, WVALID=0, WADDR=0, WE=0, WDATA=0, PTR=0. Any in-flight grant is dropped. Requesters keep REQ asserted and are re-arbitrated after reset releases.
- State:
  - PTR, ceil(log2 NREQ) bits: highest-priority index.
  - Registered output bank: GNT, WVALID, WADDR, WE, WDATA.
- Eligibility at each edge: ELIG = REQ & ~GNT. The requester granted in the current cycle is masked, so the same requester can never win two consecutive cycles.
- Arbitration at edge, when RST=0, HOLD=0 and ELIG!=0:
  - Winner w = first set bit of ELIG, searching PTR, PTR+1, ..., wrapping modulo NREQ.
  - Next cycle: GNT=one-hot(w), WVALID=1, WADDR=ADDR[w], WE=decode(ADDR[w]), WDATA=DATA[w].
  - PTR <= (w+1) mod NREQ.
- Idle: when ELIG=0 or HOLD=1, next cycle GNT=0, WVALID=0, WE=0. WADDR and WDATA keep their previous values. PTR is unchanged.
- Latency: REQ sampled high at edge t gives GNT/WE at cycle t+1, at the earliest.
- Requester contract:
  - Hold REQ, ADDR and DATA stable until GNT is seen high.
  - May drop REQ in the cycle after the GNT cycle, or keep it high to request another write. A further grant comes at the earliest 2 cycles after the previous one.
- Storage commits the write at the edge ending the WVALID cycle.
- Only one WE bit is ever high. WE=0 whenever WVALID=0.
- HOLD asserted during a WVALID cycle does not cancel that write; it blocks only the next decision.
- Single requester at NREQ=2..8 receives alternating grant/idle cycles.
- All requesters high continuously: grants rotate 0,1,...,NREQ-1,0. Worst-case wait is NREQ cycles.
- X on ADDR/DATA of non-winning requesters must not propagate to outputs.

Optional Feature:
- Macro: ZERO_REG_EN.
- Defined: register 0 is hard-wired zero.
  - A granted write with ADDR=0 still pulses GNT (consumes the request) and drives WVALID=1, WADDR=0, WDATA=data.
  - WE stays 8'h00 for that write, so storage never changes register 0.
- Undefined: address 0 is written like any other address (WE=8'h01).

Test Plan:
1. Reset/idle: RST=1 for 2 cycles with REQ=4'b1111 → GNT=0, WE=0, WVALID=0, WDATA=0 during reset. First grant GNT=4'b0001 arrives one cycle after RST falls.
2. Single write: REQ[2]=1, ADDR[2]=3'd5, DATA[2]=8'hA5 at edge t → cycle t+1: GNT=4'b0100, WE=8'h20, WADDR=5, WDATA=8'hA5, WVALID=1. REQ dropped → cycle t+2 all idle.
3. Round-robin fairness: REQ=4'b1111 held for 8 cycles, addresses 0..3 → GNT sequence 0001,0010,0100,1000,0001,... with no idle cycles and WE tracking each requester's ADDR.
4. Back-to-back same requester: only REQ[1] held high, ADDR=3'd7, DATA=8'h3C → GNT[1] and WE=8'h80 on alternate cycles only, with WVALID=0 between them.
5. HOLD and reset mid-operation:
   - REQ=4'b0011 with HOLD=1 for 3 cycles → no grants and PTR unchanged; first grant after HOLD falls is GNT=4'b0001.
   - RST pulsed during a WVALID cycle → next cycle all outputs zero, PTR=0.
6. ZERO_REG_EN: compile with and without the macro, then issue REQ[0] with ADDR=0, DATA=8'hFF.
   - Defined: GNT=4'b0001, WVALID=1, WE=8'h00.
   - Undefined: WE=8'h01.
